// File: rtl/nios_system_keys_in.sv
// ---------------------------------------------------------------------------
// nios_system_keys_in
//
// Avalon-MM input PIO slave that brings the board push-buttons (left, right,
// start) into the Nios II. The raw pins go through a two-flop synchroniser.
// The synchronised level is readable at address 0. Per-bit edges are latched
// into a sticky edge-capture register. A maskable level interrupt is raised
// from the masked captures. Reads are zero-wait-state.
//
// Register map (word addresses):
//   0 : data        (RO) current input level
//   1 : reserved    (RO) reads 0, writes ignored
//   2 : irqmask     (RW) per-bit interrupt enable
//   3 : edgecapture (RW) sticky edge flags, write 1 to clear a bit
//
// Ports:
//   clk        in   1      system clock
//   reset_n    in   1      asynchronous active-low reset
//   address    in   2      word address
//   chipselect in   1      slave select
//   write_n    in   1      active-low write strobe
//   writedata  in   32     write data
//   in_port    in   WIDTH  raw asynchronous button inputs
//   readdata   out  32     read data, combinational from registers
//   irq        out  1      level interrupt, |(edgecapture & irqmask)
//
// Parameters:
//   WIDTH           number of input bits (1..32)
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any edge
//   RESET_VALUE     idle level of the pins, loaded into the synchroniser and
//                   delay flops so that reset release creates no edge
//   DEBOUNCE_CYCLES stable-cycle count of the debounce filter (>= 2)
//
// Optional feature:
//   Define KEYS_IN_DEBOUNCE_EN to insert a per-bit debounce filter between
//   the synchroniser and the level/edge logic. Without it the level is the
//   synchroniser output and no counters exist.
// ---------------------------------------------------------------------------
module nios_system_keys_in #(
    parameter int unsigned       WIDTH           = 4,
    parameter int unsigned       EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE     = WIDTH'(4'hF),
    parameter int unsigned       DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_RSVD  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    // Zero-extend a WIDTH-bit register to the 32-bit bus.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r          = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] delay_q, delay_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;

    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] edge_s;
    logic             wr_s;
    logic [WIDTH-1:0] wr_bits_s;

    // Upper write-data bits are not stored when WIDTH < 32.
    logic             unused_wdata_s;
    assign unused_wdata_s = ^writedata;

    assign wr_s      = chipselect & ~write_n;
    assign wr_bits_s = writedata[WIDTH-1:0];

    // Synchroniser and delay next-state: two flops to resolve metastability,
    // then one flop of the filtered level for edge detection.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        delay_d = level_s;
    end

    // Synchroniser and delay registers; idle level at reset avoids a
    // spurious edge when reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
            delay_q <= RESET_VALUE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            delay_q <= delay_d;
        end
    end

`ifdef KEYS_IN_DEBOUNCE_EN
    localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Debounce next-state: a bit's counter runs while the synchronised input
    // disagrees with the accepted level; the level flips only once the
    // disagreement has lasted DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = ~stable_q[i];
                    cnt_d[i]    = {CNT_W{1'b0}};
                end else begin
                    cnt_d[i]    = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = {CNT_W{1'b0}};
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= RESET_VALUE;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_s = stable_q;
`else
    assign level_s = sync2_q;
`endif

    // Edge vector selected by EDGE_TYPE; unknown values fall back to any-edge.
    always_comb begin
        case (EDGE_TYPE)
            32'd0:   edge_s = level_s & ~delay_q;
            32'd1:   edge_s = ~level_s & delay_q;
            32'd2:   edge_s = level_s ^ delay_q;
            default: edge_s = level_s ^ delay_q;
        endcase
    end

    // Mask and capture next-state. A detected edge has priority over a
    // write-1-to-clear on the same bit so a press is never lost.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_s && (address == ADDR_MASK)) begin
            irqmask_d = wr_bits_s;
        end else begin
            irqmask_d = irqmask_q;
        end
        if (wr_s && (address == ADDR_EDGE)) begin
            edgecap_d = (edgecap_q & ~wr_bits_s) | edge_s;
        end else begin
            edgecap_d = edgecap_q | edge_s;
        end
    end

    // Mask and capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= {WIDTH{1'b0}};
            edgecap_q <= {WIDTH{1'b0}};
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Interrupt is a pure function of registers so it rises in the same
    // cycle the capture bit sets and drops with an asynchronous reset.
    assign irq = |(edgecap_q & irqmask_q);

    // Zero-wait-state read mux; no side effects, independent of chipselect.
    always_comb begin
        case (address)
            ADDR_DATA: readdata = zext(level_s);
            ADDR_RSVD: readdata = 32'd0;
            ADDR_MASK: readdata = zext(irqmask_q);
            ADDR_EDGE: readdata = zext(edgecap_q);
            default:   readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_nios_system_keys_in.sv
module tb_nios_system_keys_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int total;
    int bad;

    // Reference model (default parameters: 4 bits, falling-edge capture).
    // h[0] is the pin value sampled at the latest clock, h[1] the one before...
    logic [3:0] h [3];
    logic [3:0] m_mask;
    logic [3:0] m_cap;

    nios_system_keys_in dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        h[0] = 4'hF; h[1] = 4'hF; h[2] = 4'hF;
        m_mask = 4'h0;
        m_cap  = 4'h0;
    endtask

    // One clock: drive bus/pins, advance the model, return 1 ns after the edge.
    // A pin level sampled at clock e is readable after e+1; a key press
    // (1->0) between samples e-1 and e is captured at clock e+2.
    task automatic cycle(input logic cs, input logic wn, input logic [1:0] wa,
                         input logic [31:0] wd, input logic [3:0] pins);
        logic [3:0] fell;
        chipselect = cs; write_n = wn; address = wa; writedata = wd; in_port = pins;
        fell = h[2] & ~h[1];
        if (cs && !wn) begin
            if (wa == 2'd2) m_mask = wd[3:0];
            else if (wa == 2'd3) m_cap = m_cap & ~wd[3:0];
        end
        m_cap = m_cap | fell;
        @(posedge clk);
        h[2] = h[1]; h[1] = h[0]; h[0] = pins;
        #1;
        write_n = 1'b1; chipselect = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'd0;
        model_reset();
        #3;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq_in_reset got=%b exp=0", irq); end
        repeat (2) @(posedge clk);
        #5 reset_n = 1'b1;
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hF);
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hF);
        for (int a = 0; a < 4; a++) begin
            logic [31:0] exp;
            address = a[1:0]; #1;
            exp = (a == 0) ? 32'h0000000F : 32'd0;
            total++;
            if (readdata !== exp) begin bad++; $display("FAIL reset_read addr=%0d got=%h exp=%h", a, readdata, exp); end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_edge_irq();
        cycle(1'b1, 1'b0, 2'd2, 32'h1, 4'hF);
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hE);
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hE);
        address = 2'd0; #1;
        total++;
        if (readdata !== 32'hE) begin bad++; $display("FAIL edge_level got=%h exp=0000000e", readdata); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL edge_irq_early got=%b exp=0", irq); end
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hE);
        address = 2'd3; #1;
        total++;
        if (readdata !== 32'h1) begin bad++; $display("FAIL edge_capture got=%h exp=00000001", readdata); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL edge_irq got=%b exp=1", irq); end
        cycle(1'b1, 1'b0, 2'd3, 32'h1, 4'hE);
        address = 2'd3; #1;
        total++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            bad++; $display("FAIL edge_clear got cap=%h irq=%b exp cap=0 irq=0", readdata, irq);
        end
    endtask

    task automatic test_mask_gating();
        repeat (4) cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hF);
        cycle(1'b1, 1'b0, 2'd3, 32'hF, 4'hB);
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hB);
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hB);
        address = 2'd3; #1;
        total++;
        if (readdata !== 32'h4 || irq !== 1'b0) begin
            bad++; $display("FAIL mask_gated got cap=%h irq=%b exp cap=4 irq=0", readdata, irq);
        end
        cycle(1'b1, 1'b0, 2'd2, 32'h5, 4'hB);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL mask_enable got=%b exp=1", irq); end
        cycle(1'b1, 1'b0, 2'd2, 32'h1, 4'hB);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL mask_disable got=%b exp=0", irq); end
    endtask

    task automatic test_collision();
        repeat (4) cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hF);
        cycle(1'b1, 1'b0, 2'd3, 32'hF, 4'hD);
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hD);
        cycle(1'b1, 1'b0, 2'd3, 32'hF, 4'hD);
        address = 2'd3; #1;
        total++;
        if (readdata !== 32'h2) begin bad++; $display("FAIL collision got=%h exp=00000002", readdata); end
    endtask

    task automatic test_write_ignore_and_reset();
        cycle(1'b1, 1'b0, 2'd0, 32'hFFFFFFFF, 4'hD);
        cycle(1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 4'hD);
        for (int a = 1; a < 4; a++) begin
            logic [31:0] exp;
            address = a[1:0]; #1;
            exp = (a == 1) ? 32'd0 : (a == 2) ? {28'd0, m_mask} : {28'd0, m_cap};
            total++;
            if (readdata !== exp) begin bad++; $display("FAIL wr_ignore addr=%0d got=%h exp=%h", a, readdata, exp); end
        end
        repeat (3) cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hF);
        cycle(1'b1, 1'b0, 2'd3, 32'hF, 4'hC);
        cycle(1'b1, 1'b0, 2'd2, 32'h3, 4'hC);
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hC);
        address = 2'd3; #1;
        total++;
        if (readdata !== 32'h3 || irq !== 1'b1) begin
            bad++; $display("FAIL pre_reset got cap=%h irq=%b exp cap=3 irq=1", readdata, irq);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            bad++; $display("FAIL async_reset got cap=%h irq=%b exp cap=0 irq=0", readdata, irq);
        end
        #2 reset_n = 1'b1;
        model_reset();
        repeat (4) cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hF);
        cycle(1'b1, 1'b0, 2'd3, 32'hF, 4'hF);
    endtask

    task automatic test_random();
        logic [3:0] pins;
        pins = 4'hF;
        for (int n = 0; n < 400; n++) begin
            logic        cs;
            logic        wn;
            logic [1:0]  wa;
            logic [31:0] wd;
            if ($urandom_range(0, 3) == 0) pins = 4'($urandom);
            cs = 1'($urandom);
            wn = 1'($urandom);
            wa = 2'($urandom);
            wd = $urandom;
            cycle(cs, wn, wa, wd, pins);
            for (int a = 0; a < 4; a++) begin
                logic [31:0] exp;
                address = a[1:0]; #1;
                case (a)
                    0:       exp = {28'd0, h[1]};
                    2:       exp = {28'd0, m_mask};
                    3:       exp = {28'd0, m_cap};
                    default: exp = 32'd0;
                endcase
                total++;
                if (readdata !== exp) begin
                    bad++; $display("FAIL rand_read n=%0d addr=%0d got=%h exp=%h", n, a, readdata, exp);
                end
            end
            total++;
            if (irq !== |(m_cap & m_mask)) begin
                bad++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, |(m_cap & m_mask));
            end
        end
    endtask

    task automatic test_debounce();
        repeat (20) cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hF);
        cycle(1'b1, 1'b0, 2'd3, 32'hF, 4'hE);
        repeat (9) cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hE);
        for (int n = 0; n < 30; n++) begin
            cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hF);
            address = 2'd0; #1;
            total++;
            if (readdata !== 32'hF) begin bad++; $display("FAIL glitch_level n=%0d got=%h exp=0000000f", n, readdata); end
        end
        address = 2'd3; #1;
        total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL glitch_capture got=%h exp=00000000", readdata); end
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b0, 1'b1, 2'd0, 32'd0, 4'hE);
            address = 2'd0; #1;
            if (k == 17) begin
                total++;
                if (readdata !== 32'hF) begin bad++; $display("FAIL debounce_early got=%h exp=0000000f", readdata); end
            end else if (k == 18) begin
                total++;
                if (readdata !== 32'hE) begin bad++; $display("FAIL debounce_level got=%h exp=0000000e", readdata); end
            end
        end
        address = 2'd3; #1;
        total++;
        if (readdata !== 32'h1) begin bad++; $display("FAIL debounce_capture got=%h exp=00000001", readdata); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
`ifdef KEYS_IN_DEBOUNCE_EN
        test_debounce();
`else
        test_edge_irq();
        test_mask_gating();
        test_collision();
        test_write_ignore_and_reset();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_system_keys_in.md
Name: nios_system_keys_in

Overview:
- Avalon-MM input PIO slave that brings board push-buttons into the Nios II as player controls (left/right/start).
- Synchronises the raw input pins and exposes the current level.
- Latches per-bit edges into a sticky capture register and raises a maskable level interrupt.
- Zero-wait-state reads; same slave register style as the existing output PIOs.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 1, capture edge: 0 = rising, 1 = falling (key press on active-low keys), 2 = any.
- RESET_VALUE, 4'hF, value loaded into the synchroniser/delay flops at reset; idle level of the pins, so no spurious edge at reset release. Width is WIDTH bits.
- DEBOUNCE_CYCLES, 16, stable-cycle count required by the debounce filter (used only with KEYS_IN_DEBOUNCE_EN; must be ≥ 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  word address: 0 = data, 1 = reserved, 2 = irqmask, 3 = edgecapture.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous button inputs.
- readdata  out  32  read data; combinational from registers.
- irq  out  1  level interrupt to the CPU.

Behaviour:
- Clock: single clock clk. Reset: reset_n, asynchronous, active-low; all state clears immediately on assertion.
- Reset values:
  - sync1, sync2 and delay flops = RESET_VALUE.
  - irqmask = 0, edgecapture = 0, irq = 0.
  - readdata follows the register mux.
- Synchroniser: sync1 <= in_port; sync2 <= sync1; delay <= level, where level = sync2 (or the debounced value, see Optional Feature).
- Edge vector, per bit:
  - EDGE_TYPE 0: level & ~delay.
  - EDGE_TYPE 1: ~level & delay.
  - EDGE_TYPE 2: level ^ delay.
- Latency from in_port change sampled at edge N (no debounce):
  - Visible at address 0 after edge N+1.
  - edgecapture bit set at edge N+2; irq asserts in the same cycle.
- edgecapture, per bit, priority order:
  - Edge detected → set to 1.
  - Else write to address 3 with writedata[i] = 1 → clear.
  - Else hold.
- Simultaneous edge and clear on the same bit: set wins, and the bit stays 1.
- Bits written 0 at address 3 are unaffected.
- irqmask: written at address 2 from writedata[WIDTH-1:0]; read back at address 2.
- irq = |(edgecapture & irqmask). Pure function of registers, so there is no extra cycle.
  - Clearing a mask bit deasserts irq on the next cycle if no other bit contributes.
- Write qualification: a write occurs when chipselect && !write_n.
  - Writes to address 0 or 1 are ignored.
- Read mux, zero wait states, independent of chipselect:
  - address 0 → level.
  - address 2 → irqmask.
  - address 3 → edgecapture.
  - address 1 → 0.
  - Bits above WIDTH read as 0.
- Reads have no side effects; edgecapture is cleared only by an explicit write.
- Reset mid-operation: pending captures and mask are lost; irq drops asynchronously with reset_n.
- WIDTH = 32: no unused upper bits; all masks and clears are full-width.

Optional Feature:
- Macro: KEYS_IN_DEBOUNCE_EN.
- Defined: each bit has a counter of width clog2(DEBOUNCE_CYCLES) and a stable register.
  - The stable register resets to RESET_VALUE and counters reset to 0.
  - While sync2[i] != stable[i] the counter increments.
  - When sync2[i] == stable[i] the counter resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, stable[i] toggles and the counter resets.
  - level = stable.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no level change and no capture.
  - Added latency: DEBOUNCE_CYCLES cycles.
- Undefined: level = sync2 and no counters are instantiated.

Test Plan:
- Reset with in_port=4'hF → after release: readdata is 0 at addresses 0..3 except address 0, which reads 0x0000000F 2 cycles later; irq=0; no capture.
- EDGE_TYPE=1: write irqmask=0x1, then drive in_port 4'hF→4'hE → edgecapture=0x1 and irq=1 exactly 3 clocks after the change. Write 0x1 to address 3 → edgecapture=0, irq=0 next cycle.
- Mask gating: falling edge on bit 2 with irqmask=0x1 → edgecapture=0x4, irq stays 0. Write irqmask=0x5 → irq=1 next cycle.
- Set/clear collision: schedule a write of 0xF to address 3 in the same cycle bit 1's edge is detected → edgecapture bit 1 remains 1 after the write.
- Write ignore and reset mid-op: write 0xFFFFFFFF to addresses 0 and 1 → no register changes. With edgecapture=0x3 and irq=1, pulse reset_n low for half a cycle → irq=0 and edgecapture=0 immediately.
- KEYS_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - A 10-cycle low glitch on bit 0 → no change at address 0 and no capture.
  - A 40-cycle low pulse → address 0 reads 0xE starting 18 cycles after the input falls, and edgecapture=0x1.
